map_row_server: RTL and testbench
=================================

# map_row_server

Owner of the single map-ROM read port, serving two clients: the ray tracer (random access, highest priority) and the map overlay (raster-ordered lookups). During each hblank it prefetches the 2^MAP_WBITS cells of the next overlay map row into a ping-pong line buffer, using only ROM cycles the tracer leaves idle. The overlay then reads from the buffer combinationally and never contends with tracing. It is the responder end of the overlay's col/row → cell-value interface.

## Interface
- MAP_WBITS, 4, map column address bits (MAP_WIDTH = 2^MAP_WBITS)
- MAP_HBITS, 4, map row address bits (MAP_HEIGHT = 2^MAP_HBITS)
- MAP_SCALE, 3, log2 pixels per map cell in overlay
- H_VIEW, 640, first hblank hpos
- V_TOTAL, 525, lines per frame

- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- hpos, vpos  in  10  current raster position
- i_tr_req  in  1  tracer read request, single cycle
- i_tr_col / i_tr_row  in  MAP_WBITS / MAP_HBITS  tracer cell address
- o_tr_ack  out  1  pulses one cycle after each accepted i_tr_req
- o_tr_val  out  2  tracer cell value, valid while o_tr_ack=1 (held afterwards)
- i_ov_col / i_ov_row  in  MAP_WBITS / MAP_HBITS  overlay lookup address
- o_ov_val  out  2  overlay cell value, combinational
- o_rom_col / o_rom_row  out  MAP_WBITS / MAP_HBITS  ROM address
- i_rom_val  in  2  ROM data, combinational from o_rom_col/o_rom_row
- o_fill_miss  out  1  sticky: a row swap found its fill incomplete

## Operation
- next_line = (vpos==V_TOTAL-1) ? 0 : vpos+1.
- Trigger: hpos==H_VIEW, next_line[MAP_SCALE-1:0]==0, next_line < MAP_HEIGHT<<MAP_SCALE. Records fill_tag = next_line[MAP_SCALE+MAP_HBITS-1:MAP_SCALE], col counter ← 0, state → FILL.
- States: IDLE, FILL, DONE.
- In FILL, on every cycle with i_tr_req=0: ROM address = {fill_tag, col}, fill_bank[col] ← i_rom_val, col++. After col = MAP_WIDTH-1 is written, state → DONE. Cycles with i_tr_req=1 stall the fill and do not advance col.
- A trigger while in FILL restarts the fill with the new tag and sets o_fill_miss.
- Swap: at hpos==0 with vpos[MAP_SCALE-1:0]==0 and vpos < MAP_HEIGHT<<MAP_SCALE:
  - If state==DONE: active bank ↔ fill bank, active_tag ← fill_tag, active_valid ← 1, state → IDLE.
  - Otherwise: active_valid ← 0, o_fill_miss ← 1, state → IDLE.
- Tracer path: i_tr_req=1 always drives the ROM with {i_tr_row, i_tr_col}. The next cycle gives o_tr_val ← i_rom_val and o_tr_ack=1. Requests are accepted every cycle; no backpressure.
- ROM address when neither client is active: {0,0}.
- o_ov_val = (active_valid && i_ov_row==active_tag) ? active_bank[i_ov_col] : 0. i_ov_row is compared over all MAP_HBITS bits.
- o_fill_miss clears only on reset.

## Timing
- Reset values: state IDLE, both banks 0, active_valid 0, tags 0, o_tr_ack 0, o_tr_val 0, o_fill_miss 0, o_ov_val 0, o_rom_col/row 0.
- Reset asserted mid-fill aborts immediately. No swap occurs until the next trigger/fill/swap sequence completes.
- Tracer latency: exactly 1 cycle from request to ack.
- Fill with no tracer traffic: MAP_WIDTH cycles (16), so DONE is reached at hpos H_VIEW+16.
- Fill with tracer traffic: MAP_WIDTH plus the number of stalled cycles.
- Overlay lookup latency: 0 cycles. The active bank changes only at a swap edge.
- A trigger and a swap never coincide, because hpos differs between them.

## Configuration
- MAP_FILL_MISS_EN defined: o_fill_miss behaves as described above.
- MAP_FILL_MISS_EN undefined: the sticky register is not built, o_fill_miss is tied to 0, and a fill restart is silent. All other behaviour is identical.

## Test plan
Setup for all scenarios: ROM model i_rom_val = (col ^ row) & 3, defaults, MAP_FILL_MISS_EN defined.
1. Run to vpos=7, hpos=640 with no tracer traffic → state DONE at hpos 656. At vpos=8, hpos=0 the swap occurs; i_ov_row=1, i_ov_col=6 → o_ov_val=3, and i_ov_row=2 → 0.
2. i_tr_req on alternate cycles during that fill, col=9, row=4 → o_tr_ack one cycle later with o_tr_val=1 each time; DONE reached at hpos 672; buffer contents match scenario 1.
3. i_tr_req held high from vpos=7, hpos=640 through vpos=8, hpos=0 → o_fill_miss=1 and o_ov_val=0 for any lookup on row 1; the next row's fill (vpos=15) recovers with correct values.
4. vpos=524, hpos=640 → row 0 fill. At vpos=0, hpos=0 the swap occurs; i_ov_row=0, i_ov_col=3 → 3.
5. Drop reset_n at col 8 of a fill → all outputs return to reset values asynchronously. After release, the next trigger fills and swaps correctly.
6. vpos=127, hpos=640 → no trigger. At vpos=128, row 15 stays active and i_ov_row=0 returns 0.

Source files
------------

// File: rtl/map_row_server_if.sv
// Overlay lookup port of map_row_server: the overlay drives a column/row
// address and receives the cell value combinationally from the line buffer.
// Signal names are given from the server's point of view.
interface map_row_server_if #(
  parameter int unsigned MAP_WBITS = 4,
  parameter int unsigned MAP_HBITS = 4
);
  logic [MAP_WBITS-1:0] i_ov_col;
  logic [MAP_HBITS-1:0] i_ov_row;
  logic [1:0]           o_ov_val;

  // Overlay side: issues lookups, consumes cell values
  modport master (
    output i_ov_col,
    output i_ov_row,
    input  o_ov_val
  );

  // Server side: answers lookups from the active line-buffer bank
  modport slave (
    input  i_ov_col,
    input  i_ov_row,
    output o_ov_val
  );
endinterface

// File: rtl/map_row_server.sv
// map_row_server: owns the single map-ROM read port.
// The ray tracer gets the ROM whenever it asks (1-cycle ack, no backpressure).
// During each hblank the next overlay map row is prefetched into the idle half
// of a ping-pong line buffer using only cycles the tracer leaves free; the
// buffers are swapped at the start of the first scanline of that map row.
// The overlay reads the active bank combinationally through map_row_server_if.
// Optional feature macro: MAP_FILL_MISS_EN builds the sticky o_fill_miss flag;
// without it o_fill_miss is tied low and fill restarts are silent.
module map_row_server #(
  parameter int unsigned MAP_WBITS = 4,
  parameter int unsigned MAP_HBITS = 4,
  parameter int unsigned MAP_SCALE = 3,
  parameter int unsigned H_VIEW    = 640,
  parameter int unsigned V_TOTAL   = 525
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [9:0]           hpos,
  input  logic [9:0]           vpos,
  // tracer client
  input  logic                 i_tr_req,
  input  logic [MAP_WBITS-1:0] i_tr_col,
  input  logic [MAP_HBITS-1:0] i_tr_row,
  output logic                 o_tr_ack,
  output logic [1:0]           o_tr_val,
  // overlay client
  map_row_server_if.slave      ov,
  // map ROM
  output logic [MAP_WBITS-1:0] o_rom_col,
  output logic [MAP_HBITS-1:0] o_rom_row,
  input  logic [1:0]           i_rom_val,
  // status
  output logic                 o_fill_miss
);

  localparam int unsigned MAP_WIDTH  = 1 << MAP_WBITS;
  localparam int unsigned LINE_LIMIT = (1 << MAP_HBITS) << MAP_SCALE;
  localparam logic [MAP_WBITS-1:0] COL_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [MAP_WBITS-1:0] r_col;
  logic [MAP_HBITS-1:0] r_fill_tag;
  logic [MAP_HBITS-1:0] r_active_tag;
  logic                 r_active_valid;
  logic                 r_active_sel;   // 0: bank0 active, bank1 filling
  logic [1:0]           r_bank0 [MAP_WIDTH];
  logic [1:0]           r_bank1 [MAP_WIDTH];
  logic                 r_tr_ack;
  logic [1:0]           r_tr_val;

  logic [9:0]           w_next_line;
  logic                 w_trigger;
  logic                 w_swap;
  logic                 w_fill_we;
  logic [MAP_HBITS-1:0] w_next_tag;
  logic [1:0]           w_active_rd;

  // Raster decode: prefetch trigger at hblank start, swap at line start
  always_comb begin
    w_next_line = (vpos == 10'(V_TOTAL - 1)) ? '0 : vpos + 10'd1;
    w_next_tag  = w_next_line[MAP_SCALE+MAP_HBITS-1:MAP_SCALE];
    w_trigger   = (hpos == 10'(H_VIEW))
               && (w_next_line[MAP_SCALE-1:0] == '0)
               && (32'(w_next_line) < LINE_LIMIT);
    w_swap      = (hpos == '0)
               && (vpos[MAP_SCALE-1:0] == '0)
               && (32'(vpos) < LINE_LIMIT);
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and fill-write enable; the tracer always wins the ROM
  always_comb begin
    w_state_nxt = r_state;
    w_fill_we   = 1'b0;
    if (r_state == S_FILL && !i_tr_req) begin
      w_fill_we = 1'b1;
    end
    if (w_swap) begin
      w_state_nxt = S_IDLE;
    end else if (w_trigger) begin
      w_state_nxt = S_FILL;
    end else if (w_fill_we && r_col == COL_LAST) begin
      w_state_nxt = S_DONE;
    end
  end

  // ROM address mux: tracer, then fill, otherwise parked at {0,0}
  always_comb begin
    o_rom_col = '0;
    o_rom_row = '0;
    if (i_tr_req) begin
      o_rom_col = i_tr_col;
      o_rom_row = i_tr_row;
    end else if (r_state == S_FILL) begin
      o_rom_col = r_col;
      o_rom_row = r_fill_tag;
    end
  end

  // Fill column counter and tag capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_col      <= '0;
      r_fill_tag <= '0;
    end else if (w_trigger) begin
      r_col      <= '0;
      r_fill_tag <= w_next_tag;
    end else if (w_fill_we) begin
      r_col      <= r_col + MAP_WBITS'(1);
    end
  end

  // Line buffer writes into whichever bank is not active
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < MAP_WIDTH; i++) begin
        r_bank0[i] <= '0;
        r_bank1[i] <= '0;
      end
    end else if (w_fill_we) begin
      if (r_active_sel) begin
        r_bank0[r_col] <= i_rom_val;
      end else begin
        r_bank1[r_col] <= i_rom_val;
      end
    end
  end

  // Bank swap / invalidation at the first line of a map row
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_active_sel   <= 1'b0;
      r_active_tag   <= '0;
      r_active_valid <= 1'b0;
    end else if (w_swap) begin
      if (r_state == S_DONE) begin
        r_active_sel   <= ~r_active_sel;
        r_active_tag   <= r_fill_tag;
        r_active_valid <= 1'b1;
      end else begin
        r_active_valid <= 1'b0;
      end
    end
  end

  // Tracer response: one-cycle ack, value held until the next request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tr_ack <= 1'b0;
      r_tr_val <= '0;
    end else begin
      r_tr_ack <= i_tr_req;
      if (i_tr_req) begin
        r_tr_val <= i_rom_val;
      end
    end
  end

  assign o_tr_ack = r_tr_ack;
  assign o_tr_val = r_tr_val;

  // Overlay lookup from the active bank, zero on tag miss or invalid row
  always_comb begin
    w_active_rd = r_active_sel ? r_bank1[ov.i_ov_col] : r_bank0[ov.i_ov_col];
    ov.o_ov_val = '0;
    if (r_active_valid && ov.i_ov_row == r_active_tag) begin
      ov.o_ov_val = w_active_rd;
    end
  end

`ifdef MAP_FILL_MISS_EN
  logic r_fill_miss;
  logic w_miss_set;

  // Miss when a fill is restarted or a swap finds the fill unfinished
  always_comb begin
    w_miss_set = (w_trigger && r_state == S_FILL)
              || (w_swap && r_state != S_DONE);
  end

  // Sticky miss flag, cleared only by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fill_miss <= 1'b0;
    end else if (w_miss_set) begin
      r_fill_miss <= 1'b1;
    end
  end

  assign o_fill_miss = r_fill_miss;
`else
  assign o_fill_miss = 1'b0;
`endif

endmodule

// File: tb/tb_map_row_server.sv
// Directed bench for map_row_server. ROM model: value = (col ^ row) & 3.
// hpos/vpos are driven directly so each scenario jumps to the lines of interest.
module tb_map_row_server;

  logic       clk;
  logic       reset_n;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       tr_req;
  logic [3:0] tr_col;
  logic [3:0] tr_row;
  logic       tr_ack;
  logic [1:0] tr_val;
  logic [3:0] rom_col;
  logic [3:0] rom_row;
  logic [1:0] rom_val;
  logic       fill_miss;
  logic       miss_exp;

  int n_vec = 0;
  int n_err = 0;

  map_row_server_if #(.MAP_WBITS(4), .MAP_HBITS(4)) ov_if ();

  map_row_server #(
    .MAP_WBITS(4),
    .MAP_HBITS(4),
    .MAP_SCALE(3),
    .H_VIEW   (640),
    .V_TOTAL  (525)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .hpos       (hpos),
    .vpos       (vpos),
    .i_tr_req   (tr_req),
    .i_tr_col   (tr_col),
    .i_tr_row   (tr_row),
    .o_tr_ack   (tr_ack),
    .o_tr_val   (tr_val),
    .ov         (ov_if.slave),
    .o_rom_col  (rom_col),
    .o_rom_row  (rom_row),
    .i_rom_val  (rom_val),
    .o_fill_miss(fill_miss)
  );

  assign rom_val = 2'((rom_col ^ rom_row) & 4'd3);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic lookup(input string tag, input logic [3:0] row, input logic [3:0] col,
                        input logic [1:0] exp);
    ov_if.i_ov_row = row;
    ov_if.i_ov_col = col;
    #1;
    check(tag, 16'(ov_if.o_ov_val), 16'(exp));
  endtask

  // trigger edge at hpos 640 followed by n fill cycles
  task automatic do_fill(input logic [9:0] v, input int n);
    vpos = v;
    hpos = 10'd640;
    tick();
    for (int i = 0; i < n; i++) begin
      hpos = 10'(641 + i);
      tick();
    end
  endtask

  task automatic do_swap(input logic [9:0] v);
    vpos = v;
    hpos = 10'd0;
    tick();
    hpos = 10'd1;
  endtask

  initial begin
`ifdef MAP_FILL_MISS_EN
    miss_exp = 1'b1;
`else
    miss_exp = 1'b0;
`endif
    reset_n = 1'b0;
    hpos = 10'd700;
    vpos = 10'd7;
    tr_req = 1'b0;
    tr_col = 4'd0;
    tr_row = 4'd0;
    ov_if.i_ov_col = 4'd0;
    ov_if.i_ov_row = 4'd0;
    repeat (3) tick();

    // reset state
    check("rst_ack", 16'(tr_ack), 16'd0);
    check("rst_val", 16'(tr_val), 16'd0);
    check("rst_miss", 16'(fill_miss), 16'd0);
    check("rst_rom_col", 16'(rom_col), 16'd0);
    check("rst_rom_row", 16'(rom_row), 16'd0);
    lookup("rst_ov", 4'd0, 4'd0, 2'd0);
    reset_n = 1'b1;
    tick();

    // 1: idle-ROM fill of row 1, swap at vpos 8 after exactly 16 fill cycles
    do_fill(10'd7, 16);
    vpos = 10'd8;
    hpos = 10'd0;
    lookup("s1_pre_swap", 4'd1, 4'd6, 2'd0);
    tick();
    hpos = 10'd1;
    lookup("s1_r1c6", 4'd1, 4'd6, 2'd3);
    lookup("s1_r2c6", 4'd2, 4'd6, 2'd0);
    lookup("s1_r1c0", 4'd1, 4'd0, 2'd1);
    check("s1_miss", 16'(fill_miss), 16'd0);

    // 2: tracer on alternate cycles stretches the fill to 32 cycles
    tr_col = 4'd9;
    tr_row = 4'd4;
    vpos = 10'd7;
    hpos = 10'd640;
    tick();
    for (int i = 0; i < 32; i++) begin
      hpos = 10'(641 + i);
      tr_req = (i % 2 == 0);
      if (tr_req) begin
        #1;
        check("s2_rom_row_tr", 16'(rom_row), 16'd4);
      end
      tick();
      check("s2_ack", 16'(tr_ack), 16'(tr_req));
      check("s2_val", 16'(tr_val), 16'd1);
    end
    tr_req = 1'b0;
    do_swap(10'd8);
    lookup("s2_r1c6", 4'd1, 4'd6, 2'd3);
    lookup("s2_r1c0", 4'd1, 4'd0, 2'd1);
    lookup("s2_r1c15", 4'd1, 4'd15, 2'd2);
    check("s2_miss", 16'(fill_miss), 16'd0);

    // 4: wrap-around, vpos 524 prefetches row 0, swap at vpos 0
    do_fill(10'd524, 16);
    do_swap(10'd0);
    lookup("s4_r0c3", 4'd0, 4'd3, 2'd3);
    lookup("s4_r0c2", 4'd0, 4'd2, 2'd2);
    lookup("s4_r1c6", 4'd1, 4'd6, 2'd0);

    // 6: row 15 stays active past the bottom of the map
    do_fill(10'd119, 16);
    do_swap(10'd120);
    lookup("s6_r15c2", 4'd15, 4'd2, 2'd1);
    do_fill(10'd127, 20);
    do_swap(10'd128);
    lookup("s6_keep_r15", 4'd15, 4'd2, 2'd1);
    lookup("s6_r0", 4'd0, 4'd2, 2'd0);
    check("s6_miss", 16'(fill_miss), 16'd0);

    // 3: tracer hogs the ROM for the whole hblank, swap finds no data
    tr_col = 4'd9;
    tr_row = 4'd4;
    tr_req = 1'b1;
    do_fill(10'd7, 20);
    check("s3_ack_hold", 16'(tr_ack), 16'd1);
    do_swap(10'd8);
    tr_req = 1'b0;
    check("s3_miss", 16'(fill_miss), 16'(miss_exp));
    lookup("s3_r1c6", 4'd1, 4'd6, 2'd0);
    lookup("s3_old_r15", 4'd15, 4'd2, 2'd0);
    do_fill(10'd15, 16);
    do_swap(10'd16);
    lookup("s3_r2c5", 4'd2, 4'd5, 2'd3);
    lookup("s3_r2c0", 4'd2, 4'd0, 2'd2);
    lookup("s3_r1_after", 4'd1, 4'd6, 2'd0);
    check("s3_miss_sticky", 16'(fill_miss), 16'(miss_exp));

    // 5: asynchronous reset in the middle of a fill
    do_fill(10'd23, 8);
    check("s5_rom_col", 16'(rom_col), 16'd8);
    check("s5_rom_row", 16'(rom_row), 16'd3);
    tr_req = 1'b1;
    tick();
    tr_req = 1'b0;
    check("s5_ack_pre", 16'(tr_ack), 16'd1);
    lookup("s5_ov_pre", 4'd2, 4'd5, 2'd3);
    #1;
    reset_n = 1'b0;
    #1;
    check("s5_rst_ack", 16'(tr_ack), 16'd0);
    check("s5_rst_val", 16'(tr_val), 16'd0);
    check("s5_rst_miss", 16'(fill_miss), 16'd0);
    check("s5_rst_ov", 16'(ov_if.o_ov_val), 16'd0);
    check("s5_rst_rom_col", 16'(rom_col), 16'd0);
    check("s5_rst_rom_row", 16'(rom_row), 16'd0);
    tick();
    tick();
    #2;
    reset_n = 1'b1;
    tick();
    do_fill(10'd23, 16);
    do_swap(10'd24);
    lookup("s5_r3c1", 4'd3, 4'd1, 2'd2);
    lookup("s5_r3c7", 4'd3, 4'd7, 2'd0);
    check("s5_miss_after", 16'(fill_miss), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
